// File: rtl/pcnt_pkg.sv
// rtl/pcnt_pkg.sv - shared widths, popcount result type and saturating adder for pcnt_binarize
package pcnt_pkg;

    localparam int WORD_W    = 64;
    localparam int PCNT_W    = 8;
    localparam int IDX_W     = $clog2(WORD_W);
    localparam int SAT_MAX_W = 32;

    typedef logic signed [PCNT_W-1:0] pcnt_t;

    // Adds two values held in SAT_MAX_W bits and clamps to the signed range of a w-bit field (w < SAT_MAX_W).
    function automatic logic signed [SAT_MAX_W-1:0] sat_add(
        input logic signed [SAT_MAX_W-1:0] a,
        input logic signed [SAT_MAX_W-1:0] b,
        input int unsigned                 w
    );
        logic signed [SAT_MAX_W:0] s;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        s  = (SAT_MAX_W+1)'(a) + (SAT_MAX_W+1)'(b);
        hi = ((SAT_MAX_W+1)'(1) << (w - 1)) - (SAT_MAX_W+1)'(1);
        lo = -hi - (SAT_MAX_W+1)'(1);
        if (s > hi) begin
            sat_add = hi[SAT_MAX_W-1:0];
        end else if (s < lo) begin
            sat_add = lo[SAT_MAX_W-1:0];
        end else begin
            sat_add = s[SAT_MAX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/bit_packer.sv
// rtl/bit_packer.sv - packs activation bits LSB-first into 64-bit words, emitting on a full word or last neuron
module bit_packer
    import pcnt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_val,
    input  logic              last,
    output logic [WORD_W-1:0] stream_o,
    output logic              o_val
);

    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [WORD_W-1:0] stream_q, stream_d;
    logic              o_val_q, o_val_d;
    logic [WORD_W-1:0] pack_next;
    logic              emit;

    assign pack_next = pack_q | (WORD_W'(bit_in) << bit_idx_q);
    // A last neuron landing on bit 63 still yields a single word.
    assign emit      = bit_val && ((bit_idx_q == {IDX_W{1'b1}}) || last);

    always_comb begin
        bit_idx_d = bit_idx_q;
        pack_d    = pack_q;
        stream_d  = stream_q;
        o_val_d   = 1'b0;
        if (bit_val) begin
            if (emit) begin
                stream_d  = pack_next;
                o_val_d   = 1'b1;
                pack_d    = '0;
                bit_idx_d = '0;
            end else begin
                pack_d    = pack_next;
                bit_idx_d = bit_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_idx_q <= '0;
            pack_q    <= '0;
            stream_q  <= '0;
            o_val_q   <= 1'b0;
        end else begin
            bit_idx_q <= bit_idx_d;
            pack_q    <= pack_d;
            stream_q  <= stream_d;
            o_val_q   <= o_val_d;
        end
    end

    assign stream_o = stream_q;
    assign o_val    = o_val_q;

endmodule

// File: rtl/pcnt_binarize.sv
// rtl/pcnt_binarize.sv - accumulates popcount chunks per neuron, thresholds, and packs bits into words
// Define PCNT_BINARIZE_SAT_EN for saturating accumulation; default build wraps modulo 2^ACC_W.
module pcnt_binarize
    import pcnt_pkg::*;
#(
    parameter int N_CHUNKS = 4,
    parameter int ACC_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  pcnt_t                   stream_i,
    input  logic                    i_val,
    input  logic                    last_i,
    input  logic signed [ACC_W-1:0] thresh_i,
    output logic [WORD_W-1:0]       stream_o,
    output logic                    o_val
);

    localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNKS - 1);

    logic [CNT_W-1:0]        chunk_cnt_q, chunk_cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] stream_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    final_beat;
    logic                    act_bit;

    assign stream_ext = ACC_W'(stream_i);

`ifdef PCNT_BINARIZE_SAT_EN
    assign sum = ACC_W'(sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(stream_ext), ACC_W));
`else
    assign sum = acc_q + stream_ext;
`endif

    assign final_beat = i_val && (chunk_cnt_q == LAST_CHUNK);
    assign act_bit    = (sum >= thresh_i);

    always_comb begin
        chunk_cnt_d = chunk_cnt_q;
        acc_d       = acc_q;
        if (i_val) begin
            if (final_beat) begin
                chunk_cnt_d = '0;
                acc_d       = '0;
            end else begin
                chunk_cnt_d = chunk_cnt_q + CNT_W'(1);
                acc_d       = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chunk_cnt_q <= '0;
            acc_q       <= '0;
        end else begin
            chunk_cnt_q <= chunk_cnt_d;
            acc_q       <= acc_d;
        end
    end

    bit_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (act_bit),
        .bit_val  (final_beat),
        .last     (last_i),
        .stream_o (stream_o),
        .o_val    (o_val)
    );

endmodule

// File: tb/tb_pcnt_binarize.sv
// tb/tb_pcnt_binarize.sv - table vectors plus scoreboarded sequences for pcnt_binarize
module tb_pcnt_binarize;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [7:0]  stream_i;
    logic               i_val;
    logic               last_i;
    logic signed [15:0] thresh_i;
    logic [63:0]        stream_o;
    logic               o_val;

    logic signed [7:0]  ov_stream;
    logic               ov_val;
    logic               ov_last;
    logic signed [7:0]  ov_thresh;
    logic [63:0]        ov_stream_o;
    logic               ov_o_val;

    always #5 clk = ~clk;

    pcnt_binarize #(.N_CHUNKS(4), .ACC_W(16)) u_dut (
        .clk      (clk),
        .rst      (rst_n),
        .stream_i (stream_i),
        .i_val    (i_val),
        .last_i   (last_i),
        .thresh_i (thresh_i),
        .stream_o (stream_o),
        .o_val    (o_val)
    );

    pcnt_binarize #(.N_CHUNKS(2), .ACC_W(8)) u_ovf (
        .clk      (clk),
        .rst      (rst_n),
        .stream_i (ov_stream),
        .i_val    (ov_val),
        .last_i   (ov_last),
        .thresh_i (ov_thresh),
        .stream_o (ov_stream_o),
        .o_val    (ov_o_val)
    );

    typedef struct {
        logic [63:0] word;
        int          cyc;
    } ev_t;

    typedef struct {
        logic [31:0]        beats;
        logic signed [15:0] thr;
        logic               exp_bit;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ov_count = 0;
    ev_t         exp_q[$];
    ev_t         got_q[$];
    logic [63:0] drained[$];
    logic [63:0] ref_words[$];

    int                 m_cnt;
    int                 m_idx;
    logic signed [15:0] m_acc;
    logic [63:0]        m_pack;

    logic signed [7:0]  vals[1024];
    logic signed [15:0] thrs[256];
    vec_t               vt[9];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && o_val) begin
            got_q.push_back('{stream_o, cyc});
            ov_count++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt  = 0;
        m_idx  = 0;
        m_acc  = '0;
        m_pack = '0;
    endtask

    task automatic send(input logic signed [7:0] s, input logic signed [15:0] thr, input logic lst);
        logic signed [15:0] sm;
        @(posedge clk);
        #1;
        stream_i = s;
        thresh_i = thr;
        last_i   = lst;
        i_val    = 1'b1;
        sm = m_acc + 16'(s);
        if (m_cnt == 3) begin
            m_pack[m_idx] = (sm >= thr);
            if (m_idx == 63 || lst) begin
                exp_q.push_back('{m_pack, cyc + 1});
                m_pack = '0;
                m_idx  = 0;
            end else begin
                m_idx++;
            end
            m_acc = '0;
            m_cnt = 0;
        end else begin
            m_acc = sm;
            m_cnt++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            i_val  = 1'b0;
            last_i = 1'b0;
        end
    endtask

    task automatic drain();
        ev_t e;
        ev_t g;
        idle(3);
        drained.delete();
        chk("sb_count", 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk("sb_word", g.word, e.word);
            chk("sb_cycle", 64'(g.cyc), 64'(e.cyc));
            drained.push_back(g.word);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        int base;
        logic signed [7:0] b;

        rst_n = 1'b0;
        stream_i = '0; i_val = 1'b0; last_i = 1'b0; thresh_i = '0;
        ov_stream = '0; ov_val = 1'b0; ov_last = 1'b0; ov_thresh = '0;
        model_clear();

        vt[0] = '{32'h40C0_0000, 16'sd0, 1'b1};
        vt[1] = '{32'h40C0_0000, 16'sd1, 1'b0};
        vt[2] = '{32'h4040_4040, 16'sd256, 1'b1};
        vt[3] = '{32'h4040_4040, 16'sd257, 1'b0};
        vt[4] = '{32'hC0C0_C0C0, -16'sd256, 1'b1};
        vt[5] = '{32'hC0C0_C0C0, -16'sd255, 1'b0};
        vt[6] = '{32'h0800_0000, 16'sd0, 1'b1};
        vt[7] = '{32'hF800_0000, 16'sd0, 1'b0};
        vt[8] = '{32'hF800_0000, -16'sd8, 1'b1};

        for (int i = 0; i < 1024; i++) vals[i] = 8'($urandom_range(128)) - 8'd64;
        for (int i = 0; i < 256; i++) thrs[i] = 16'($urandom_range(80)) - 16'd40;

        repeat (3) @(negedge clk);
        chk("reset_stream", stream_o, 64'h0);
        chk("reset_val", 64'(o_val), 64'h0);
        chk("reset_ov_stream", ov_stream_o, 64'h0);
        chk("reset_ov_val", 64'(ov_o_val), 64'h0);
        @(posedge clk); #2; rst_n = 1'b1;

        // Each table row is one neuron closed with last_i, so every row yields a one-bit word.
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = vt[i].beats[31 - 8*k -: 8];
                send(b, vt[i].thr, (k == 3));
            end
        end
        drain();
        for (int i = 0; i < 9; i++) chk($sformatf("table_%0d", i), drained[i], {63'b0, vt[i].exp_bit});

        base = ov_count;
        for (int i = 0; i < 256; i++) send(8'sh40, 16'sd0, 1'b0);
        drain();
        chk("ones_count", 64'(ov_count - base), 64'd1);
        chk("ones_word", drained[0], 64'hFFFF_FFFF_FFFF_FFFF);
        idle(5);
        @(negedge clk);
        chk("hold_word", stream_o, 64'hFFFF_FFFF_FFFF_FFFF);

        base = ov_count;
        for (int n = 0; n < 3; n++) begin
            b = (n == 1) ? -8'sd8 : 8'sd8;
            send(b, 16'sd0, 1'b0);
            send(8'sd0, 16'sd0, 1'b0);
            send(8'sd0, 16'sd0, 1'b0);
            send(8'sd0, 16'sd0, (n == 2));
        end
        drain();
        chk("flush_count", 64'(ov_count - base), 64'd1);
        chk("flush_word", drained[0], 64'h5);

        base = ov_count;
        for (int i = 0; i < 1024; i++) send(vals[i], thrs[i/4], 1'b0);
        drain();
        chk("nogap_count", 64'(ov_count - base), 64'd4);
        ref_words = drained;
        base = ov_count;
        for (int i = 0; i < 1024; i++) begin
            if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
            send(vals[i], thrs[i/4], 1'b0);
        end
        drain();
        chk("gap_count", 64'(ov_count - base), 64'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("gap_word_%0d", i), drained[i], ref_words[i]);

        // Four all-ones neurons plus two beats of neuron 5 are discarded by the reset.
        for (int i = 0; i < 18; i++) send(8'sh40, 16'sd0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        i_val = 1'b0;
        model_clear();
        @(negedge clk);
        chk("midrst_stream", stream_o, 64'h0);
        chk("midrst_val", 64'(o_val), 64'h0);
        @(posedge clk); #2; rst_n = 1'b1;
        base = ov_count;
        for (int i = 0; i < 255; i++) send(((i/4) % 2 == 1) ? 8'sh40 : -8'sh40, 16'sd0, 1'b0);
        idle(2);
        chk("midrst_early", 64'(ov_count - base), 64'd0);
        send(8'sh40, 16'sd0, 1'b0);
        idle(2);
        chk("midrst_emit", 64'(ov_count - base), 64'd1);
        drain();
        chk("midrst_word", drained[0], 64'hAAAA_AAAA_AAAA_AAAA);

        ov_thresh = '0;
        ov_last   = 1'b1;
        @(posedge clk); #1; ov_stream = 8'sd64; ov_val = 1'b1;
        @(posedge clk); #1; ov_stream = 8'sd64;
        @(posedge clk); #1; ov_val = 1'b0;
        @(negedge clk);
        chk("ovf_val", 64'(ov_o_val), 64'h1);
`ifdef PCNT_BINARIZE_SAT_EN
        chk("ovf_word", ov_stream_o, 64'h1);
`else
        chk("ovf_word", ov_stream_o, 64'h0);
`endif
        @(negedge clk);
        chk("ovf_pulse", 64'(ov_o_val), 64'h0);

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
